// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bundle: pipeline-register inputs, branch decision and write-back outputs.
// Latency: none inside the interface itself; it only carries wires.
// Backpressure: none; the pipeline advances on every clock.
interface mem_stage_if;
    // Control and data coming out of the EX/MEM pipeline register
    logic        MEM_memtoreg;
    logic        MEM_regwrite;
    logic        MEM_memread;
    logic        MEM_memwrite;
    logic        MEM_branch;
    logic [31:0] MEM_branch_PC;
    logic        MEM_zero;
    logic [31:0] MEM_aluresult;
    logic [31:0] MEM_readda2;
    logic [4:0]  MEM_writereg;

    // Branch decision back to fetch
    logic        PCSrc;
    logic [31:0] PC_branch;

    // MEM/WB pipeline register contents
    logic        WB_memtoreg;
    logic        WB_regwrite;
    logic [31:0] WB_readdata;
    logic [31:0] WB_aluresult;
    logic [4:0]  WB_writereg;
    logic        mem_err;

    // Upstream side: drives the EX/MEM fields, observes the results
    modport master (
        output MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite, MEM_branch,
        output MEM_branch_PC, MEM_zero, MEM_aluresult, MEM_readda2, MEM_writereg,
        input  PCSrc, PC_branch,
        input  WB_memtoreg, WB_regwrite, WB_readdata, WB_aluresult, WB_writereg, mem_err
    );

    // The memory stage itself
    modport slave (
        input  MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite, MEM_branch,
        input  MEM_branch_PC, MEM_zero, MEM_aluresult, MEM_readda2, MEM_writereg,
        output PCSrc, PC_branch,
        output WB_memtoreg, WB_regwrite, WB_readdata, WB_aluresult, WB_writereg, mem_err
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: word-addressed data RAM, branch decision, MEM/WB register, sticky misalign flag.
// Latency: PCSrc/PC_branch combinational; load data and WB_ fields one clk edge after sampling.
// Backpressure: none; every edge advances the stage unconditionally.
module mem_stage #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              aligned;
    logic              rd_ok;
    logic              wr_ok;
    logic              access_err;
    logic [31:0]       rd_nxt;

    // Upper address bits are dropped so addresses wrap around the RAM
    assign idx        = bus.MEM_aluresult[ADDR_W+1:2];
    assign aligned    = (bus.MEM_aluresult[1:0] == 2'b00);
    assign rd_ok      = bus.MEM_memread  && aligned;
    assign wr_ok      = bus.MEM_memwrite && aligned;
    assign access_err = !aligned && (bus.MEM_memread || bus.MEM_memwrite);

    // Branch decision stays combinational, independent of reset
    assign bus.PCSrc     = bus.MEM_branch && bus.MEM_zero;
    assign bus.PC_branch = bus.MEM_branch_PC;

    // Load data: misaligned or absent loads return zero
    always_comb begin
        rd_nxt = 32'h0;
        if (rd_ok) begin
            rd_nxt = mem[idx];
        end
    end

    // MEM/WB register and RAM write; the read samples pre-write contents,
    // and a store on an edge seen during reset is dropped because the
    // reset branch wins. RAM contents are deliberately left out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.WB_memtoreg  <= 1'b0;
            bus.WB_regwrite  <= 1'b0;
            bus.WB_readdata  <= 32'h0;
            bus.WB_aluresult <= 32'h0;
            bus.WB_writereg  <= 5'd0;
            bus.mem_err      <= 1'b0;
        end else begin
            bus.WB_memtoreg  <= bus.MEM_memtoreg;
            bus.WB_regwrite  <= bus.MEM_regwrite;
            bus.WB_readdata  <= rd_nxt;
            bus.WB_aluresult <= bus.MEM_aluresult;
            bus.WB_writereg  <= bus.MEM_writereg;
            if (access_err) begin
                bus.mem_err <= 1'b1;
            end
            if (wr_ok) begin
                mem[idx] <= bus.MEM_readda2;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle behaviour plus an async-reset sequence.
// Latency: checks combinational outputs 1ns after drive, registered outputs 1ns after the edge.
// Backpressure: not applicable; stimulus advances one vector per clock.
module tb_mem_stage;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mem_stage_if bus();

    mem_stage #(.ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        rw;
        logic        br;
        logic        zr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] bpc;
        logic [4:0]  wreg;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_pcsrc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdat,
                                input logic m2r, input logic rw, input logic [4:0] wreg,
                                input logic br, input logic zr, input logic [31:0] bpc,
                                input logic [31:0] exp_rd, input logic exp_err,
                                input logic exp_pcsrc);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.addr = addr; v.wdat = wdat;
        v.m2r = m2r; v.rw = rw; v.wreg = wreg; v.br = br; v.zr = zr; v.bpc = bpc;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_pcsrc = exp_pcsrc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.MEM_memread   = v.rd;
        bus.MEM_memwrite  = v.wr;
        bus.MEM_memtoreg  = v.m2r;
        bus.MEM_regwrite  = v.rw;
        bus.MEM_branch    = v.br;
        bus.MEM_zero      = v.zr;
        bus.MEM_branch_PC = v.bpc;
        bus.MEM_aluresult = v.addr;
        bus.MEM_readda2   = v.wdat;
        bus.MEM_writereg  = v.wreg;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " WB_memtoreg"},  {31'h0, bus.WB_memtoreg}, 32'h0);
        chk({tag, " WB_regwrite"},  {31'h0, bus.WB_regwrite}, 32'h0);
        chk({tag, " WB_readdata"},  bus.WB_readdata,          32'h0);
        chk({tag, " WB_aluresult"}, bus.WB_aluresult,         32'h0);
        chk({tag, " WB_writereg"},  {27'h0, bus.WB_writereg}, 32'h0);
        chk({tag, " mem_err"},      {31'h0, bus.mem_err},     32'h0);
    endtask

    vec_t idle;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //           name          rd wr addr          wdat          m2r rw wreg br zr bpc       exp_rd        err pcs
        vecs[0]  = mk("st10",       0, 1, 32'h10,       32'hDEADBEEF, 0, 0, 5'd0, 0, 0, 32'h0,  32'h0,        0, 0);
        vecs[1]  = mk("ld10",       1, 0, 32'h10,       32'h0,        1, 1, 5'd5, 0, 0, 32'h0,  32'hDEADBEEF, 0, 0);
        vecs[2]  = mk("st20",       0, 1, 32'h20,       32'h1,        0, 0, 5'd0, 0, 0, 32'h0,  32'h0,        0, 0);
        vecs[3]  = mk("rdwr20",     1, 1, 32'h20,       32'h2,        1, 1, 5'd9, 0, 0, 32'h0,  32'h1,        0, 0);
        vecs[4]  = mk("ld20",       1, 0, 32'h20,       32'h0,        1, 1, 5'd9, 0, 0, 32'h0,  32'h2,        0, 0);
        vecs[5]  = mk("st404",      0, 1, 32'h404,      32'hA5A5A5A5, 0, 0, 5'd0, 0, 0, 32'h0,  32'h0,        0, 0);
        vecs[6]  = mk("ld004",      1, 0, 32'h004,      32'h0,        1, 1, 5'd3, 0, 0, 32'h0,  32'hA5A5A5A5, 0, 0);
        vecs[7]  = mk("st3fc",      0, 1, 32'h3FC,      32'h12345678, 0, 0, 5'd0, 0, 0, 32'h0,  32'h0,        0, 0);
        vecs[8]  = mk("ldfffffffc", 1, 0, 32'hFFFFFFFC, 32'h0,        1, 1, 5'd31,0, 0, 32'h0,  32'h12345678, 0, 0);
        vecs[9]  = mk("mis_idle",   0, 0, 32'h13,       32'h0,        0, 1, 5'd2, 1, 1, 32'h40, 32'h0,        0, 1);
        vecs[10] = mk("br_nz",      0, 0, 32'h0,        32'h0,        0, 0, 5'd0, 1, 0, 32'h40, 32'h0,        0, 0);
        vecs[11] = mk("st13_mis",   0, 1, 32'h13,       32'hFFFFFFFF, 0, 0, 5'd0, 0, 0, 32'h0,  32'h0,        1, 0);
        vecs[12] = mk("ld12_mis",   1, 0, 32'h12,       32'h0,        1, 1, 5'd6, 0, 0, 32'h0,  32'h0,        1, 0);
        vecs[13] = mk("ld10_keep",  1, 0, 32'h10,       32'h0,        1, 1, 5'd7, 0, 0, 32'h0,  32'hDEADBEEF, 1, 0);
        vecs[14] = mk("noread10",   0, 0, 32'h10,       32'h0,        0, 1, 5'd8, 0, 1, 32'h0,  32'h0,        1, 0);
        vecs[15] = mk("br_z_only",  0, 0, 32'h0,        32'h0,        0, 0, 5'd0, 0, 1, 32'h80, 32'h0,        1, 0);
        idle     = mk("idle",       0, 0, 32'h0,        32'h0,        0, 0, 5'd0, 0, 0, 32'h0,  32'h0,        0, 0);

        // Reset entry with a genuine falling edge on rst_n
        drive(idle);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: drive at the falling edge, check combinational, then registered
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            #1;
            chk({vecs[i].name, " PCSrc"},     {31'h0, bus.PCSrc}, {31'h0, vecs[i].exp_pcsrc});
            chk({vecs[i].name, " PC_branch"}, bus.PC_branch,      vecs[i].bpc);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " WB_readdata"},  bus.WB_readdata,          vecs[i].exp_rd);
            chk({vecs[i].name, " mem_err"},      {31'h0, bus.mem_err},     {31'h0, vecs[i].exp_err});
            chk({vecs[i].name, " WB_aluresult"}, bus.WB_aluresult,         vecs[i].addr);
            chk({vecs[i].name, " WB_writereg"},  {27'h0, bus.WB_writereg}, {27'h0, vecs[i].wreg});
            chk({vecs[i].name, " WB_regwrite"},  {31'h0, bus.WB_regwrite}, {31'h0, vecs[i].rw});
            chk({vecs[i].name, " WB_memtoreg"},  {31'h0, bus.WB_memtoreg}, {31'h0, vecs[i].m2r});
            @(negedge clk);
        end

        // Async reset mid-cycle while WB_regwrite is high and mem_err is set
        drive(mk("pre_rst", 1, 0, 32'h10, 32'h0, 1, 1, 5'd7, 0, 0, 32'h0, 32'h0, 0, 0));
        @(posedge clk);
        #1;
        chk("pre_rst WB_regwrite", {31'h0, bus.WB_regwrite}, 32'h1);
        chk("pre_rst mem_err",     {31'h0, bus.mem_err},     32'h1);
        #2;
        // A store and a taken branch presented while reset is asserted
        drive(mk("st_in_rst", 0, 1, 32'h20, 32'h00000BAD, 0, 1, 5'd4, 1, 1, 32'h44, 32'h0, 0, 1));
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        chk("rst PCSrc",     {31'h0, bus.PCSrc}, 32'h1);
        chk("rst PC_branch", bus.PC_branch,      32'h44);
        @(posedge clk);
        #1;
        check_reset_state("held_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Memory survives reset and the store seen during reset was dropped
        drive(mk("ld20_post", 1, 0, 32'h20, 32'h0, 1, 1, 5'd1, 0, 0, 32'h0, 32'h0, 0, 0));
        @(posedge clk);
        #1;
        chk("post_rst ld20 WB_readdata", bus.WB_readdata,          32'h2);
        chk("post_rst WB_regwrite",      {31'h0, bus.WB_regwrite}, 32'h1);
        @(negedge clk);
        drive(mk("ld10_post", 1, 0, 32'h10, 32'h0, 1, 1, 5'd1, 0, 0, 32'h0, 32'h0, 0, 0));
        @(posedge clk);
        #1;
        chk("post_rst ld10 WB_readdata", bus.WB_readdata,      32'hDEADBEEF);
        chk("post_rst mem_err",          {31'h0, bus.mem_err}, 32'h0);
        @(negedge clk);
        drive(idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
